// File: rtl/alarm_controller_if.sv
// alarm_controller_if: bundles the live time, user controls and alarm outputs
// of the alarm stage. The controller connects through the slave modport; the
// driver of time/controls (counter chain, UI, bench) uses the master modport.
interface alarm_controller_if;
    logic       tick_1hz;
    logic [5:0] count_sec;
    logic [5:0] count_min;
    logic [4:0] count_hour;
    logic       alarm_en;
    logic       alarm_set;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       stop;
    logic       snooze;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       ringing;
    logic       snoozing;
    logic       buzzer;
    logic       led_blink;

    modport master (
        output tick_1hz, count_sec, count_min, count_hour,
        output alarm_en, alarm_set, set_hour, set_min, stop, snooze,
        input  alarm_hour, alarm_min, ringing, snoozing, buzzer, led_blink
    );

    modport slave (
        input  tick_1hz, count_sec, count_min, count_hour,
        input  alarm_en, alarm_set, set_hour, set_min, stop, snooze,
        output alarm_hour, alarm_min, ringing, snoozing, buzzer, led_blink
    );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller: alarm stage fed by the HH:MM:SS counter chain. Stores an
// alarm time, rings (buzzer square wave + blinking LED) on a rising edge of
// the time match, and returns to ARMED on stop, timeout or a new alarm load.
// Optional feature macro: ALARM_SNOOZE_EN builds the SNOOZE state and its
// counters; without it the snooze input is ignored and snoozing is 0.
module alarm_controller #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int BUZZ_HALF      = 25000
) (
    input logic               clk,
    input logic               rst_a_n,
    alarm_controller_if.slave bus
);
    localparam int RING_W = $clog2(RING_SECONDS + 1);
    localparam int BUZZ_W = $clog2(BUZZ_HALF + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_HALF - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W  = $clog2(SNOOZE_SECONDS + 1);
    localparam int USED_W = $clog2(MAX_SNOOZE + 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD = SNZ_W'(SNOOZE_SECONDS);
    localparam logic [USED_W-1:0] USED_MAX = USED_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RINGING, ST_SNOOZE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RINGING} state_t;
`endif

    state_t            r_state;
    logic [4:0]        r_alarm_hour;
    logic [5:0]        r_alarm_min;
    logic              r_eq_q;
    logic [RING_W-1:0] r_ring_cnt;
    logic [BUZZ_W-1:0] r_buzz_cnt;
    logic              r_ringing;
    logic              r_buzzer;
    logic              r_led;
`ifdef ALARM_SNOOZE_EN
    logic              r_snoozing;
    logic [SNZ_W-1:0]  r_snooze_cnt;
    logic [USED_W-1:0] r_snooze_used;
`endif

    logic w_set_valid;
    logic w_eq;
    logic w_hit;

    assign w_set_valid = (bus.set_hour <= 5'd23) && (bus.set_min <= 6'd59);
    assign w_eq        = (bus.count_hour == r_alarm_hour) &&
                         (bus.count_min  == r_alarm_min)  &&
                         (bus.count_sec  == 6'd0);
    // Rising edge only: sitting on the alarm time never re-triggers.
    assign w_hit       = w_eq && !r_eq_q;

    // Alarm time registers: load only in-range values, ignore the rest.
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_alarm_hour <= '0;
            r_alarm_min  <= '0;
        end else if (bus.alarm_set && w_set_valid) begin
            r_alarm_hour <= bus.set_hour;
            r_alarm_min  <= bus.set_min;
        end
    end

    // Match history, updated every cycle in every state. Resets to 1 so that
    // a clock already at the alarm time when released from reset cannot ring.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_eq_q <= 1'b1;
        end else begin
            r_eq_q <= w_eq;
        end
    end

    // Main FSM with registered outputs, ring/buzzer/snooze counters.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_state       <= ST_IDLE;
            r_ring_cnt    <= '0;
            r_buzz_cnt    <= '0;
            r_ringing     <= 1'b0;
            r_buzzer      <= 1'b0;
            r_led         <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snoozing    <= 1'b0;
            r_snooze_cnt  <= '0;
            r_snooze_used <= '0;
`endif
        end else if (!bus.alarm_en) begin
            r_state   <= ST_IDLE;
            r_ringing <= 1'b0;
            r_buzzer  <= 1'b0;
            r_led     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snoozing <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                end

                ST_ARMED: begin
                    if (w_hit) begin
                        r_state    <= ST_RINGING;
                        r_ringing  <= 1'b1;
                        r_ring_cnt <= '0;
                        r_buzz_cnt <= '0;
                        r_buzzer   <= 1'b1;
                        r_led      <= 1'b1;
`ifdef ALARM_SNOOZE_EN
                        r_snooze_used <= '0;
`endif
                    end
                end

                ST_RINGING: begin
                    if (bus.alarm_set || bus.stop) begin
                        // Stop also swallows a same-cycle tick.
                        r_state   <= ST_ARMED;
                        r_ringing <= 1'b0;
                        r_buzzer  <= 1'b0;
                        r_led     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.snooze && (r_snooze_used < USED_MAX)) begin
                        r_state       <= ST_SNOOZE;
                        r_ringing     <= 1'b0;
                        r_snoozing    <= 1'b1;
                        r_buzzer      <= 1'b0;
                        r_led         <= 1'b0;
                        r_snooze_cnt  <= SNZ_LOAD;
                        r_snooze_used <= r_snooze_used + 1'b1;
`endif
                    end else if (bus.tick_1hz && (r_ring_cnt == RING_LAST)) begin
                        r_state   <= ST_ARMED;
                        r_ringing <= 1'b0;
                        r_buzzer  <= 1'b0;
                        r_led     <= 1'b0;
                    end else begin
                        if (r_buzz_cnt == BUZZ_LAST) begin
                            r_buzz_cnt <= '0;
                            r_buzzer   <= ~r_buzzer;
                        end else begin
                            r_buzz_cnt <= r_buzz_cnt + 1'b1;
                        end
                        if (bus.tick_1hz) begin
                            r_ring_cnt <= r_ring_cnt + 1'b1;
                            r_led      <= ~r_led;
                        end
                    end
                end

`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (bus.alarm_set || bus.stop) begin
                        r_state    <= ST_ARMED;
                        r_snoozing <= 1'b0;
                    end else if (bus.tick_1hz) begin
                        if (r_snooze_cnt == SNZ_W'(1)) begin
                            r_state    <= ST_RINGING;
                            r_snoozing <= 1'b0;
                            r_ringing  <= 1'b1;
                            r_ring_cnt <= '0;
                            r_buzz_cnt <= '0;
                            r_buzzer   <= 1'b1;
                            r_led      <= 1'b1;
                        end else begin
                            r_snooze_cnt <= r_snooze_cnt - 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    r_state   <= ST_IDLE;
                    r_ringing <= 1'b0;
                    r_buzzer  <= 1'b0;
                    r_led     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alarm_hour = r_alarm_hour;
    assign bus.alarm_min  = r_alarm_min;
    assign bus.ringing    = r_ringing;
    assign bus.buzzer     = r_buzzer;
    assign bus.led_blink  = r_led;
`ifdef ALARM_SNOOZE_EN
    assign bus.snoozing   = r_snoozing;
`else
    assign bus.snoozing   = 1'b0;

    // Snooze input and snooze parameters have no function in this build.
    logic w_unused_snooze;
    assign w_unused_snooze = bus.snooze ^ (SNOOZE_SECONDS == 0) ^ (MAX_SNOOZE == 0);
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed bench for alarm_controller with default
// parameters. Snooze scenarios follow ALARM_SNOOZE_EN.
module tb_alarm_controller;
    logic clk;
    logic rst_a_n;
    int   total;
    int   bad;

    alarm_controller_if bus ();

    alarm_controller dut (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .bus     (bus)
    );

    // Output vector {ringing, snoozing, buzzer, led_blink}.
    logic [3:0]  outs;
    logic [10:0] alarm_reg;
    assign outs      = {bus.ringing, bus.snoozing, bus.buzzer, bus.led_blink};
    assign alarm_reg = {bus.alarm_hour, bus.alarm_min};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.count_hour = h;
        bus.count_min  = m;
        bus.count_sec  = s;
    endtask

    task automatic pulse_tick();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        step();
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
    endtask

    task automatic load_alarm(input logic [4:0] h, input logic [5:0] m);
        bus.set_hour  = h;
        bus.set_min   = m;
        bus.alarm_set = 1'b1;
        step();
        bus.alarm_set = 1'b0;
    endtask

    // Walk the time onto 07:30:00 from one second before.
    task automatic make_ring();
        set_time(5'd7, 6'd29, 6'd59);
        step();
        set_time(5'd7, 6'd30, 6'd0);
        step();
    endtask

    task automatic test_reset();
        rst_a_n       = 1'b0;
        bus.tick_1hz  = 1'b0;
        bus.alarm_en  = 1'b0;
        bus.alarm_set = 1'b0;
        bus.set_hour  = '0;
        bus.set_min   = '0;
        bus.stop      = 1'b0;
        bus.snooze    = 1'b0;
        set_time(5'd0, 6'd0, 6'd0);
        repeat (3) step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outs: got %b expected %b", outs, 4'b0000);
        end
        total++;
        if (alarm_reg !== 11'd0) begin
            bad++;
            $display("FAIL reset_alarm: got %0d:%0d expected 0:0", bus.alarm_hour, bus.alarm_min);
        end
        @(negedge clk);
        rst_a_n = 1'b1;
        step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_no_ring_at_enable();
        bus.alarm_en = 1'b1;
        repeat (5) step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL enable_at_match: got %b expected %b", outs, 4'b0000);
        end
        set_time(5'd0, 6'd0, 6'd1);
        step();
        set_time(5'd0, 6'd0, 6'd0);
        step();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL downcount_ring: got %b expected %b", outs, 4'b1011);
        end
        pulse_stop();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL downcount_stop: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_trigger();
        load_alarm(5'd7, 6'd30);
        total++;
        if (alarm_reg !== {5'd7, 6'd30}) begin
            bad++;
            $display("FAIL load_0730: got %0d:%0d expected 7:30", bus.alarm_hour, bus.alarm_min);
        end
        set_time(5'd7, 6'd29, 6'd59);
        repeat (2) step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL pre_match: got %b expected %b", outs, 4'b0000);
        end
        set_time(5'd7, 6'd30, 6'd0);
        step();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL trig_ring: got %b expected %b", outs, 4'b1011);
        end
        // Buzzer stays high for 25000 cycles counted from the entry edge.
        repeat (24999) step();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL buzz_half_hold: got %b expected %b", outs, 4'b1011);
        end
        step();
        total++;
        if (outs !== 4'b1001) begin
            bad++;
            $display("FAIL buzz_toggle: got %b expected %b", outs, 4'b1001);
        end
        pulse_tick();
        total++;
        if (outs !== 4'b1000) begin
            bad++;
            $display("FAIL led_tick1: got %b expected %b", outs, 4'b1000);
        end
        pulse_tick();
        total++;
        if (outs !== 4'b1001) begin
            bad++;
            $display("FAIL led_tick2: got %b expected %b", outs, 4'b1001);
        end
        repeat (57) pulse_tick();
        total++;
        if (bus.ringing !== 1'b1) begin
            bad++;
            $display("FAIL ring_tick59: got %b expected 1", bus.ringing);
        end
        pulse_tick();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL ring_timeout: got %b expected %b", outs, 4'b0000);
        end
        repeat (3) step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL timeout_hold: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_invalid_load();
        set_time(5'd12, 6'd0, 6'd0);
        step();
        load_alarm(5'd24, 6'd10);
        total++;
        if (alarm_reg !== {5'd7, 6'd30}) begin
            bad++;
            $display("FAIL bad_hour: got %0d:%0d expected 7:30", bus.alarm_hour, bus.alarm_min);
        end
        load_alarm(5'd5, 6'd60);
        total++;
        if (alarm_reg !== {5'd7, 6'd30}) begin
            bad++;
            $display("FAIL bad_min: got %0d:%0d expected 7:30", bus.alarm_hour, bus.alarm_min);
        end
        load_alarm(5'd23, 6'd59);
        total++;
        if (alarm_reg !== {5'd23, 6'd59}) begin
            bad++;
            $display("FAIL edge_2359: got %0d:%0d expected 23:59", bus.alarm_hour, bus.alarm_min);
        end
        load_alarm(5'd7, 6'd30);
        total++;
        if (alarm_reg !== {5'd7, 6'd30}) begin
            bad++;
            $display("FAIL reload_0730: got %0d:%0d expected 7:30", bus.alarm_hour, bus.alarm_min);
        end
    endtask

    task automatic test_stop_retrigger();
        make_ring();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL rt_ring: got %b expected %b", outs, 4'b1011);
        end
        pulse_stop();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL rt_stop: got %b expected %b", outs, 4'b0000);
        end
        repeat (5) step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL rt_hold: got %b expected %b", outs, 4'b0000);
        end
        set_time(5'd7, 6'd30, 6'd1);
        step();
        set_time(5'd7, 6'd30, 6'd0);
        step();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL rt_rering: got %b expected %b", outs, 4'b1011);
        end
        pulse_stop();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL rt_stop2: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_snooze();
        make_ring();
`ifdef ALARM_SNOOZE_EN
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            total++;
            if (outs !== 4'b0100) begin
                bad++;
                $display("FAIL snz_enter%0d: got %b expected %b", k, outs, 4'b0100);
            end
            repeat (299) pulse_tick();
            total++;
            if (outs !== 4'b0100) begin
                bad++;
                $display("FAIL snz_wait%0d: got %b expected %b", k, outs, 4'b0100);
            end
            pulse_tick();
            total++;
            if (outs !== 4'b1011) begin
                bad++;
                $display("FAIL snz_rering%0d: got %b expected %b", k, outs, 4'b1011);
            end
        end
        pulse_snooze();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL snz_limit: got %b expected %b", outs, 4'b1011);
        end
`else
        pulse_snooze();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL snz_ignored: got %b expected %b", outs, 4'b1011);
        end
        pulse_snooze();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL snz_ignored2: got %b expected %b", outs, 4'b1011);
        end
`endif
        pulse_stop();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL snz_stop: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_priority();
        make_ring();
        bus.stop     = 1'b1;
        bus.tick_1hz = 1'b1;
        step();
        bus.stop     = 1'b0;
        bus.tick_1hz = 1'b0;
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL stop_tick: got %b expected %b", outs, 4'b0000);
        end
        make_ring();
        bus.stop   = 1'b1;
        bus.snooze = 1'b1;
        step();
        bus.stop   = 1'b0;
        bus.snooze = 1'b0;
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL stop_snooze: got %b expected %b", outs, 4'b0000);
        end
        make_ring();
        load_alarm(5'd7, 6'd30);
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL set_in_ring: got %b expected %b", outs, 4'b0000);
        end
        make_ring();
        bus.alarm_en = 1'b0;
        bus.stop     = 1'b1;
        step();
        bus.stop     = 1'b0;
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL disable_stop: got %b expected %b", outs, 4'b0000);
        end
        set_time(5'd7, 6'd30, 6'd1);
        step();
        set_time(5'd7, 6'd30, 6'd0);
        step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL idle_no_ring: got %b expected %b", outs, 4'b0000);
        end
        bus.alarm_en = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_ring();
        make_ring();
        total++;
        if (outs !== 4'b1011) begin
            bad++;
            $display("FAIL mid_ring: got %b expected %b", outs, 4'b1011);
        end
        rst_a_n = 1'b0;
        #2;
        total++;
        if ({outs, alarm_reg} !== 15'd0) begin
            bad++;
            $display("FAIL async_reset: got %b %0d:%0d expected 0000 0:0",
                     outs, bus.alarm_hour, bus.alarm_min);
        end
        @(negedge clk);
        rst_a_n = 1'b1;
        repeat (2) step();
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL post_reset: got %b expected %b", outs, 4'b0000);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_no_ring_at_enable();
        test_trigger();
        test_invalid_load();
        test_stop_retrigger();
        test_snooze();
        test_priority();
        test_reset_mid_ring();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm stage that sits directly downstream of the HH:MM:SS up/down counter chain. It consumes the live `count_hour`/`count_min`/`count_sec` values and the 1 Hz enable, and holds a programmable alarm time. When the clock reaches that time it drives a buzzer tone and a blinking LED until the user stops it, snoozes it, or the ring times out. All logic runs in the 50 MHz domain, with a single-cycle `tick_1hz` used as a clock enable.

## Interface
- `RING_SECONDS`, 60: ticks of continuous ringing before auto-stop.
- `SNOOZE_SECONDS`, 300: ticks spent in SNOOZE before re-ringing.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event.
- `BUZZ_HALF`, 25000: clk cycles per buzzer half-period (1 kHz at 50 MHz).
- `clk` in 1: 50 MHz system clock.
- `rst_a_n` in 1: asynchronous reset, active-low.
- `tick_1hz` in 1: one-`clk`-cycle pulse per second.
- `count_sec` in 6: live seconds, 0–59.
- `count_min` in 6: live minutes, 0–59.
- `count_hour` in 5: live hours, 0–23.
- `alarm_en` in 1: level; 0 forces IDLE.
- `alarm_set` in 1: single-cycle pulse; loads `set_hour`/`set_min`.
- `set_hour` in 5: alarm hour to load.
- `set_min` in 6: alarm minute to load.
- `stop` in 1: single-cycle pulse (debounced upstream).
- `snooze` in 1: single-cycle pulse (debounced upstream).
- `alarm_hour` out 5: stored alarm hour.
- `alarm_min` out 6: stored alarm minute.
- `ringing` out 1: high in RINGING.
- `snoozing` out 1: high in SNOOZE.
- `buzzer` out 1: square wave while ringing, else 0.
- `led_blink` out 1: toggles on each `tick_1hz` while ringing, else 0.

## Operation
- **Reset values:** `alarm_hour`=0, `alarm_min`=0, all other outputs 0, state IDLE, `eq_q`=1.
- **Alarm load:** `alarm_set` loads the alarm registers only if `set_hour`≤23 and `set_min`≤59. Out-of-range values are ignored and the registers are unchanged.
- **Match detection:**
  - `eq` = (`count_hour`==`alarm_hour`) && (`count_min`==`alarm_min`) && (`count_sec`==0).
  - `eq_q` registers `eq` every cycle, in every state.
  - `hit` = `eq` && !`eq_q`, i.e. a rising edge of `eq`.
  - Down-counting through HH:MM:00 also triggers the alarm.
  - Enabling the alarm while the clock already sits at the alarm time does not ring.
- **States:**
  - IDLE: if `alarm_en` → ARMED.
  - ARMED: on `hit` → RINGING; `ring_cnt`=0 and `snooze_used`=0.
  - RINGING:
    - `stop` → ARMED.
    - `snooze` with `snooze_used`<`MAX_SNOOZE` → SNOOZE; `snooze_cnt`=`SNOOZE_SECONDS`; `snooze_used`+1.
    - `snooze` at the limit is ignored.
    - `ring_cnt` increments on each `tick_1hz`; on the tick that makes it equal `RING_SECONDS` → ARMED.
  - SNOOZE:
    - `snooze_cnt` decrements on each `tick_1hz`; on the tick that makes it 0 → RINGING with `ring_cnt`=0.
    - `stop` → ARMED.
    - `snooze` is ignored.
- **Priority within one cycle** (highest first): reset, `!alarm_en` (→ IDLE from any state), `alarm_set` (→ ARMED when in RINGING/SNOOZE; registers loaded), `stop`, `snooze`, tick/timeout, `hit`.
- **Buzzer:** 0 outside RINGING. On entering RINGING, `buzz_cnt` clears and `buzzer` starts at 1. It toggles every `BUZZ_HALF` clk cycles.
- **LED:** 0 outside RINGING. It is set to 1 on entering RINGING and toggles on each subsequent `tick_1hz`.
- **Widths:** counters are sized with `$clog2(param+1)`. Comparisons are unsigned; no wrap-around is possible.

## Timing
- All outputs are registered.
- `hit` in cycle N → `ringing`=1, `buzzer`=1, `led_blink`=1 from edge N+1.
- `stop` or `snooze` sampled at edge N → `ringing`=0 after edge N (state updates at N). `buzzer`/`led_blink` go to 0 at the same edge.
- `alarm_set` at edge N → `alarm_hour`/`alarm_min` valid after edge N.
- Asynchronous reset mid-ring drops all outputs immediately and clears the snooze history.
- `tick_1hz` and `stop` in the same cycle: `stop` wins, and the tick is not counted.

## Configuration
- **`ALARM_SNOOZE_EN` defined:** SNOOZE state, `snooze_cnt` and `snooze_used` are present as described.
- **`ALARM_SNOOZE_EN` undefined:**
  - SNOOZE state and its counters are not built.
  - The `snooze` input is ignored.
  - `snoozing` is tied to 0.
  - RINGING exits only via `stop`, timeout, `alarm_set`, or `!alarm_en`.

## Test plan
- **Trigger:** reset; load 07:30; `alarm_en`=1; drive the time from 07:29:59 to 07:30:00 → `ringing`=1 one clk later. `buzzer` toggles every 25000 clk. `led_blink` toggles per tick. Auto-return to ARMED after 60 ticks.
- **Invalid load:** `alarm_set` with hour=24, min=10 → `alarm_hour`/`alarm_min` stay 07/30.
- **Stop and re-trigger:** ring, then pulse `stop` → `ringing`=0 next edge and the state stays ARMED. Holding time at 07:30:00 does not re-ring; leave and re-enter 07:30:00 → rings again.
- **Snooze:** ring, then `snooze` ×3 with 300 ticks each → `snoozing`=1 and re-ring after 300 ticks every time. A 4th `snooze` is ignored and `ringing` stays 1. With `ALARM_SNOOZE_EN` undefined, `snooze` never affects state.
- **No ring at enable:** time is 00:00:00, alarm 00:00 at reset, assert `alarm_en` → no ring. Down-count 00:00:01 → 00:00:00 after leaving the match → ring.
- **Reset and priority:** deassert `rst_a_n` mid-ring → all outputs 0 immediately. `stop`+`tick_1hz` in the same cycle → ARMED with `ring_cnt` not incremented. `alarm_en`=0 with `stop` → IDLE.
